// File: rtl/instr_mem_responder.sv
// Instruction-fetch responder: accepts byte-addressed fetch requests and
// returns words from a loader-writable store after WAIT_CYCLES wait states.
module instr_mem_responder #(
  parameter int               ADDR_W      = 8,
  parameter int               DATA_W      = 32,
  parameter int               DEPTH       = 64,
  parameter int               WAIT_CYCLES = 1,
  parameter logic [DATA_W-1:0] NOP_WORD   = 32'h00000013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  input  logic              flush,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_instr,
  output logic [ADDR_W-1:0] resp_addr,
  output logic              misaligned_err,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);
  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [3:0]        cnt;
  logic              accept, misal;
  logic              unused_wr_lsb;

  assign accept        = (state == S_IDLE) && req_valid && !flush;
  assign misal         = |req_addr[1:0];
  assign unused_wr_lsb = ^wr_addr[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (accept)             state_nxt = misal ? S_RESP : S_WAIT;
      S_WAIT: if (flush)              state_nxt = S_IDLE;
              else if (cnt == 4'd0)   state_nxt = S_RESP;
      S_RESP: if (flush || resp_ready) state_nxt = S_IDLE;
      default:                        state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == S_IDLE);
    resp_valid = (state == S_RESP);
  end

  // Response registers only move on accept and WAIT exit, so they stay
  // frozen through RESP regardless of loader writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_instr     <= '0;
      resp_addr      <= '0;
      misaligned_err <= 1'b0;
      cnt            <= 4'd0;
    end else if (accept) begin
      resp_addr <= req_addr;
      if (misal) begin
        resp_instr     <= NOP_WORD;
        misaligned_err <= 1'b1;
      end else begin
        cnt <= 4'(WAIT_CYCLES - 1);
      end
    end else if (state == S_WAIT && !flush) begin
      if (cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end else begin
        resp_instr     <= mem[resp_addr[IDX_W+1:2]];
        misaligned_err <= 1'b0;
      end
    end
  end

  // Nonblocking read above and write here give read-before-write on a shared edge.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr[IDX_W+1:2]] <= wr_data;
  end
endmodule

// File: tb/tb_instr_mem_responder.sv
// Directed bench: instance a runs with one wait state, instance b with three.
`timescale 1ns/1ps
module tb_instr_mem_responder;
  localparam logic [31:0] W1 = 32'h00500093;
  localparam logic [31:0] WA = 32'hAAAA0001;
  localparam logic [31:0] WB = 32'hBBBB0002;
  localparam logic [31:0] WC = 32'hCCCC0003;
  localparam logic [31:0] W3 = 32'h00C00113;

  logic clk, rst;
  logic wr_en;
  logic [7:0] wr_addr;
  logic [31:0] wr_data;

  logic a_req_valid, a_flush, a_resp_ready, a_req_ready, a_resp_valid, a_mis;
  logic [7:0] a_req_addr, a_resp_addr;
  logic [31:0] a_resp_instr;
  logic b_req_valid, b_flush, b_resp_ready, b_req_ready, b_resp_valid, b_mis;
  logic [7:0] b_req_addr, b_resp_addr;
  logic [31:0] b_resp_instr;

  int passed = 0;
  int total  = 0;

  instr_mem_responder #(.WAIT_CYCLES(1)) u_a (
    .clk(clk), .rst(rst), .req_valid(a_req_valid), .req_addr(a_req_addr),
    .req_ready(a_req_ready), .flush(a_flush), .resp_valid(a_resp_valid),
    .resp_ready(a_resp_ready), .resp_instr(a_resp_instr), .resp_addr(a_resp_addr),
    .misaligned_err(a_mis), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data));

  instr_mem_responder #(.WAIT_CYCLES(3)) u_b (
    .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_addr(b_req_addr),
    .req_ready(b_req_ready), .flush(b_flush), .resp_valid(b_resp_valid),
    .resp_ready(b_resp_ready), .resp_instr(b_resp_instr), .resp_addr(b_resp_addr),
    .misaligned_err(b_mis), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_a(input string tag, input logic rr, input logic rv);
    chk({tag, ".req_ready"},  32'(a_req_ready),  32'(rr));
    chk({tag, ".resp_valid"}, 32'(a_resp_valid), 32'(rv));
  endtask

  task automatic chk_a_resp(input string tag, input logic [31:0] ins, input logic [7:0] ad,
                            input logic mis);
    chk({tag, ".resp_valid"}, 32'(a_resp_valid), 32'd1);
    chk({tag, ".instr"},      a_resp_instr,      ins);
    chk({tag, ".addr"},       32'(a_resp_addr),  32'(ad));
    chk({tag, ".mis"},        32'(a_mis),        32'(mis));
  endtask

  task automatic load(input logic [7:0] ad, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = ad; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    a_req_valid = 0; a_req_addr = '0; a_flush = 0; a_resp_ready = 0;
    b_req_valid = 0; b_req_addr = '0; b_flush = 0; b_resp_ready = 0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // reset state
    chk_a("rst", 1'b1, 1'b0);
    chk("rst.instr", a_resp_instr, 32'h0);
    chk("rst.addr",  32'(a_resp_addr), 32'h0);
    chk("rst.mis",   32'(a_mis), 32'h0);
    chk("rst.b_rv",  32'(b_resp_valid), 32'h0);

    load(8'h04, W1);
    load(8'h08, WA);
    load(8'h0C, W3);

    // basic fetch, one wait state
    a_req_valid = 1; a_req_addr = 8'h04; a_resp_ready = 1;
    tick();
    a_req_valid = 0;
    chk_a("basic.wait", 1'b0, 1'b0);
    tick();
    chk_a_resp("basic", W1, 8'h04, 1'b0);
    tick();
    chk_a("basic.idle", 1'b1, 1'b0);

    // backpressure on three-wait-state instance; address change while busy is ignored
    b_req_valid = 1; b_req_addr = 8'h08; b_resp_ready = 0;
    tick();
    b_req_valid = 0; b_req_addr = 8'h10;
    tick();
    chk("bp.e1.rv", 32'(b_resp_valid), 32'd0);
    chk("bp.e1.rr", 32'(b_req_ready),  32'd0);
    tick();
    chk("bp.e2.rv", 32'(b_resp_valid), 32'd0);
    tick();
    chk("bp.e3.rv",    32'(b_resp_valid), 32'd1);
    chk("bp.e3.instr", b_resp_instr, WA);
    chk("bp.e3.addr",  32'(b_resp_addr), 32'h08);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("bp.hold%0d.rv", i),    32'(b_resp_valid), 32'd1);
      chk($sformatf("bp.hold%0d.instr", i), b_resp_instr, WA);
      chk($sformatf("bp.hold%0d.rr", i),    32'(b_req_ready), 32'd0);
    end
    b_resp_ready = 1;
    tick();
    chk("bp.idle.rr", 32'(b_req_ready),  32'd1);
    chk("bp.idle.rv", 32'(b_resp_valid), 32'd0);

    // misaligned request
    a_req_valid = 1; a_req_addr = 8'h06;
    tick();
    a_req_valid = 0;
    chk_a_resp("misal", 32'h00000013, 8'h06, 1'b1);
    tick();
    chk_a("misal.idle", 1'b1, 1'b0);

    // flush with req_valid in IDLE: not accepted
    a_req_valid = 1; a_req_addr = 8'h04; a_flush = 1;
    tick();
    a_req_valid = 0; a_flush = 0;
    chk_a("flidle", 1'b1, 1'b0);

    // flush during WAIT: response never appears
    a_req_valid = 1; a_req_addr = 8'h08;
    tick();
    a_req_valid = 0; a_flush = 1;
    tick();
    a_flush = 0;
    chk_a("flwait", 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("flwait.quiet%0d", i), 32'(a_resp_valid), 32'd0);
    end
    a_req_valid = 1; a_req_addr = 8'h0C;
    tick();
    a_req_valid = 0;
    tick();
    chk_a_resp("afterfl", W3, 8'h0C, 1'b0);
    tick();

    // flush in RESP, with and without resp_ready
    a_resp_ready = 0;
    a_req_valid = 1; a_req_addr = 8'h04;
    tick();
    a_req_valid = 0;
    tick();
    chk("flresp0.pre", 32'(a_resp_valid), 32'd1);
    a_flush = 1;
    tick();
    a_flush = 0;
    chk_a("flresp0", 1'b1, 1'b0);
    a_req_valid = 1; a_req_addr = 8'h04;
    tick();
    a_req_valid = 0;
    tick();
    chk("flresp1.pre", 32'(a_resp_valid), 32'd1);
    a_flush = 1; a_resp_ready = 1;
    tick();
    a_flush = 0;
    chk_a("flresp1", 1'b1, 1'b0);

    // write on the WAIT-exit edge: old word returned
    a_req_valid = 1; a_req_addr = 8'h08;
    tick();
    a_req_valid = 0;
    load(8'h08, WB);
    chk_a_resp("rbw", WA, 8'h08, 1'b0);
    tick();

    // write on the accept edge: new word returned; write during RESP is not seen
    load(8'h08, WA);
    a_resp_ready = 0;
    a_req_valid = 1; a_req_addr = 8'h08;
    load(8'h08, WB);
    a_req_valid = 0;
    tick();
    chk_a_resp("wfirst", WB, 8'h08, 1'b0);
    load(8'h08, WC);
    chk_a_resp("wresp", WB, 8'h08, 1'b0);
    a_resp_ready = 1;
    tick();
    chk_a("wresp.idle", 1'b1, 1'b0);

    // asynchronous reset mid-cycle while holding a misaligned response
    a_resp_ready = 0;
    a_req_valid = 1; a_req_addr = 8'h06;
    tick();
    a_req_valid = 0;
    chk("arst.pre", 32'(a_resp_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk_a("arst", 1'b1, 1'b0);
    chk("arst.instr", a_resp_instr, 32'h0);
    chk("arst.addr",  32'(a_resp_addr), 32'h0);
    chk("arst.mis",   32'(a_mis), 32'h0);
    tick();
    rst = 1'b0;
    tick();
    chk_a("arst.after", 1'b1, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
